alu_issue_ctrl: RTL

- Drives the ALU's one-hot control vector and operands from a binary opcode request.
- Waits a per-operation latency, then captures the 2*BITS ALU result into the Z register pair (z_hi/z_lo).
- Presents the captured result to the bus datapath with a valid/ready handshake.
- Sits between the control unit and the ALU and forms the issuing and consuming end of the ALU's ctrl_signal / operationResult interface.

---
 rtl/alu_issue_ctrl_pkg.sv | 31 +++
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu_issue_ctrl_encoder.sv | 22 ++
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode indices, state encoding and helpers for the ALU issue controller
// and any control-unit logic that decodes the same opcode space.
package alu_issue_ctrl_pkg;

  localparam int SIG_COUNT_DEF = 12;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_DIV = 3;
  localparam int unsigned OP_SHR = 4;
  localparam int unsigned OP_SHL = 5;
  localparam int unsigned OP_ROR = 6;
  localparam int unsigned OP_ROL = 7;
  localparam int unsigned OP_AND = 8;
  localparam int unsigned OP_OR  = 9;
  localparam int unsigned OP_NEG = 10;
  localparam int unsigned OP_NOT = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Multiply and divide are the only multi-cycle operations.
  function automatic logic is_muldiv(input int unsigned op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and result-bus signals of the issue controller; the controller
// takes the slave view, the control unit / ALU / consumer side the master view.
interface alu_issue_ctrl_if #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12,
  parameter int OP_BITS   = 4
);
  logic                 op_valid;
  logic                 op_ready;
  logic [OP_BITS-1:0]   opcode;
  logic [BITS-1:0]      x_in;
  logic [BITS-1:0]      y_in;
  logic [SIG_COUNT-1:0] alu_ctrl;
  logic [BITS-1:0]      alu_x;
  logic [BITS-1:0]      alu_y;
  logic [2*BITS-1:0]    alu_result;
  logic [BITS-1:0]      z_hi;
  logic [BITS-1:0]      z_lo;
  logic                 res_valid;
  logic                 res_ready;
  logic                 op_err;

  modport master (
    output op_valid, opcode, x_in, y_in, alu_result, res_ready,
    input  op_ready, alu_ctrl, alu_x, alu_y, z_hi, z_lo, res_valid, op_err
  );

  modport slave (
    input  op_valid, opcode, x_in, y_in, alu_result, res_ready,
    output op_ready, alu_ctrl, alu_x, alu_y, z_hi, z_lo, res_valid, op_err
  );
endinterface

// File: rtl/alu_issue_ctrl_encoder.sv
// Binary opcode to one-hot ALU control, with a flag for indices beyond the
// control vector. Purely combinational so the control unit can reuse it.
module alu_op_encoder #(
  parameter int OP_BITS   = 4,
  parameter int SIG_COUNT = 12
) (
  input  logic [OP_BITS-1:0]   opcode,
  output logic [SIG_COUNT-1:0] onehot,
  output logic                 out_of_range
);
  localparam logic [OP_BITS:0] LIMIT = (OP_BITS + 1)'(SIG_COUNT);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through it can leave a latch behind.
    onehot       = '0;
    out_of_range = ({1'b0, opcode} >= LIMIT);
    for (int i = 0; i < SIG_COUNT; i++) begin
      onehot[i] = !out_of_range && (opcode == OP_BITS'(i));
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time: drives one-hot control and operands for
// the operation's latency, captures the double-width result into Z, hands it off.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int SIG_COUNT  = SIG_COUNT_DEF,
  parameter int OP_BITS    = 4,
  parameter int MULDIV_LAT = 4
) (
  input logic             clk,
  input logic             clr,
  alu_issue_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MULDIV_LAT + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [SIG_COUNT-1:0] r_ctrl;
  logic [BITS-1:0]      r_x;
  logic [BITS-1:0]      r_y;
  logic [BITS-1:0]      r_z_hi;
  logic [BITS-1:0]      r_z_lo;
  logic                 r_op_err;
  logic [SIG_COUNT-1:0] w_onehot;
  logic                 w_oor;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_capture;

  alu_op_encoder #(
    .OP_BITS   (OP_BITS),
    .SIG_COUNT (SIG_COUNT)
  ) u_op_encoder (
    .opcode       (bus.opcode),
    .onehot       (w_onehot),
    .out_of_range (w_oor)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_accept = bus.op_valid;
        if (bus.op_valid && !w_oor) begin
          w_load      = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt    <= '0;
      r_ctrl   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z_hi   <= '0;
      r_z_lo   <= '0;
      r_op_err <= 1'b0;
    end else begin
      r_op_err <= w_accept && w_oor;
      if (w_accept) begin
        r_x <= bus.x_in;
        r_y <= bus.y_in;
      end
      if (w_load) begin
        r_ctrl <= w_onehot;
        r_cnt  <= is_muldiv(32'(bus.opcode)) ? CNT_W'(MULDIV_LAT) : CNT_W'(1);
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Capture edge: control drops with the same edge that latches the result.
      if (w_capture) begin
        r_ctrl <= '0;
        r_z_hi <= bus.alu_result[2*BITS-1:BITS];
        r_z_lo <= bus.alu_result[BITS-1:0];
      end
    end
  end

  // op_ready is gated by clr directly so it drops without waiting for an edge.
  assign bus.op_ready  = (r_state == S_IDLE) && !clr;
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.alu_ctrl  = r_ctrl;
  assign bus.alu_x     = r_x;
  assign bus.alu_y     = r_y;
  assign bus.z_hi      = r_z_hi;
  assign bus.z_lo      = r_z_lo;
  assign bus.op_err    = r_op_err;
endmodule
